// File: rtl/des_pkg.sv
// des_pkg: shared constants, FSM encoding and key-rotation tables for the DES job scheduler
package des_pkg;
  localparam int DW_DEF = 64;
  localparam int ROUNDS_DEF = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  localparam logic [1:0] ENC_SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  // decrypt starts unrotated (C0D0 already yields K16) and then rotates right
  localparam logic [1:0] DEC_SHIFT [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  function automatic logic [1:0] shift_of(input logic [3:0] round, input logic decrypt);
    return decrypt ? DEC_SHIFT[round] : ENC_SHIFT[round];
  endfunction
endpackage

// File: rtl/des_shift_schedule.sv
// des_shift_schedule: per-round key rotation amount lookup
module des_shift_schedule
  import des_pkg::*;
(
  input  logic [3:0] round,
  input  logic       decrypt,
  output logic [1:0] shift
);
  assign shift = shift_of(round, decrypt);
endmodule

// File: rtl/des_job_scheduler.sv
// des_job_scheduler: round-robin two-port arbiter and load/round/capture sequencer for the DES round core
module des_job_scheduler
  import des_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_key,
  input  logic [DW-1:0] a_data,
  input  logic          a_decrypt,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_key,
  input  logic [DW-1:0] b_data,
  input  logic          b_decrypt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          core_load,
  output logic [DW-1:0] core_key,
  output logic [DW-1:0] core_din,
  output logic          core_decrypt,
  output logic          core_step,
  output logic [3:0]    core_round,
  output logic [1:0]    core_shift,
  output logic          core_last,
  input  logic [DW-1:0] core_result
);
  logic [2:0] state;
  logic [3:0] cnt;
  logic last, id, dec, idle, gnt_a, gnt_b;
  logic [DW-1:0] key, din, res;
  logic [1:0] sched;

  assign idle = state == S_IDLE;
  // on a tie the port that did not win last time is granted
  assign gnt_a = a_valid & (~b_valid | last == ID_B);
  assign gnt_b = b_valid & (~a_valid | last == ID_A);
  assign a_ready = idle & gnt_a;
  assign b_ready = idle & gnt_b;
  assign busy = ~idle;
  assign core_load = state == S_LOAD;
  assign core_step = state == S_ROUND;
  assign core_round = cnt;
  assign core_last = core_step & (cnt == 4'(ROUNDS - 1));
  assign core_shift = core_step ? sched : 2'd0;
  assign core_key = key;
  assign core_din = din;
  assign core_decrypt = dec;
  assign rsp_valid = state == S_RESP;
  assign rsp_id = id;
  assign rsp_data = res;

  des_shift_schedule u_sched (
    .round(cnt),
    .decrypt(dec),
    .shift(sched)
  );

  // job sequencing: accept and latch, load core, step rounds, capture result, hold response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      last <= ID_B;
      id <= ID_A;
      dec <= 1'b0;
      key <= '0;
      din <= '0;
      res <= '0;
    end else begin
      case (state)
        S_IDLE: if (a_ready | b_ready) begin
          state <= S_LOAD;
          id <= gnt_b ? ID_B : ID_A;
          last <= gnt_b ? ID_B : ID_A;
          key <= gnt_b ? b_key : a_key;
          din <= gnt_b ? b_data : a_data;
          dec <= gnt_b ? b_decrypt : a_decrypt;
        end
        S_LOAD: begin
          state <= S_ROUND;
          cnt <= '0;
        end
        S_ROUND: begin
          cnt <= cnt + 4'd1;
          if (core_last) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res <= core_result;
          state <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
